// File: rtl/unidade_busca.sv
// Instruction fetch unit: drives a synchronous-read instruction memory and
// presents a registered instruction, its PC and a valid flag to decode.
module unidade_busca #(
   parameter int                      LARGURA_END  = 10,
   parameter int                      LARGURA_DADO = 32,
   parameter logic [LARGURA_DADO-1:0] PALAVRA_FIM  = '0
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    stall,
   input  logic                    desvio,
   input  logic [LARGURA_END-1:0]  alvo_desvio,
   input  logic [LARGURA_DADO-1:0] instr_mem,
   output logic [LARGURA_END-1:0]  endereco,
   output logic [LARGURA_DADO-1:0] instrucao,
   output logic [LARGURA_END-1:0]  pc_instr,
   output logic                    valido,
   output logic                    fim,
   output logic [15:0]             contador
);

   typedef enum logic [1:0] {INICIO, BUSCA, FIM} estado_t;

   estado_t                 estado_q, estado_d;
   logic [LARGURA_END-1:0]  pc_q, pc_d;
   logic [LARGURA_END-1:0]  pc_resp_q, pc_resp_d;
   logic [LARGURA_DADO-1:0] instrucao_q, instrucao_d;
   logic [LARGURA_END-1:0]  pc_instr_q, pc_instr_d;
   logic                    valido_q, valido_d;
   logic                    fim_q, fim_d;
   logic [15:0]             contador_q, contador_d;

   logic [LARGURA_END-1:0]  pc_inc;
   logic [LARGURA_END-1:0]  alvo_inc;

   assign pc_inc   = pc_q + LARGURA_END'(1);
   assign alvo_inc = alvo_desvio + LARGURA_END'(1);

   // Re-issuing pc_resp while frozen keeps instr_mem showing the same word.
   always_comb begin
      endereco = pc_q;
      if (desvio) begin
         endereco = alvo_desvio;
      end else if (estado_q == FIM || (estado_q == BUSCA && stall)) begin
         endereco = pc_resp_q;
      end
   end

   always_comb begin
      estado_d    = estado_q;
      pc_d        = pc_q;
      pc_resp_d   = pc_resp_q;
      instrucao_d = instrucao_q;
      pc_instr_d  = pc_instr_q;
      valido_d    = valido_q;
      fim_d       = fim_q;
      contador_d  = contador_q;

      if (desvio) begin
         // Redirect beats stall and terminator; the word in flight is wrong-path.
         pc_resp_d = alvo_desvio;
         pc_d      = alvo_inc;
         valido_d  = 1'b0;
         fim_d     = 1'b0;
         estado_d  = BUSCA;
      end else begin
         case (estado_q)
            INICIO: begin
               pc_resp_d = pc_q;
               pc_d      = pc_inc;
               valido_d  = 1'b0;
               estado_d  = BUSCA;
            end
            BUSCA: begin
               if (stall) begin
                  estado_d = BUSCA;
               end else if (instr_mem == PALAVRA_FIM) begin
                  valido_d = 1'b0;
                  fim_d    = 1'b1;
                  estado_d = FIM;
               end else begin
                  instrucao_d = instr_mem;
                  pc_instr_d  = pc_resp_q;
                  valido_d    = 1'b1;
                  pc_resp_d   = pc_q;
                  pc_d        = pc_inc;
                  if (contador_q != 16'hFFFF) begin
                     contador_d = contador_q + 16'd1;
                  end
               end
            end
            FIM: begin
               valido_d = 1'b0;
            end
            default: begin
               estado_d = INICIO;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         estado_q    <= INICIO;
         pc_q        <= '0;
         pc_resp_q   <= '0;
         instrucao_q <= '0;
         pc_instr_q  <= '0;
         valido_q    <= 1'b0;
         fim_q       <= 1'b0;
         contador_q  <= '0;
      end else begin
         estado_q    <= estado_d;
         pc_q        <= pc_d;
         pc_resp_q   <= pc_resp_d;
         instrucao_q <= instrucao_d;
         pc_instr_q  <= pc_instr_d;
         valido_q    <= valido_d;
         fim_q       <= fim_d;
         contador_q  <= contador_d;
      end
   end

   assign instrucao = instrucao_q;
   assign pc_instr  = pc_instr_q;
   assign valido    = valido_q;
   assign fim       = fim_q;
   assign contador  = contador_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: directed vector table, hand-written corner
// sequences, and random stimulus against an address-stream reference model.
module tb_unidade_busca;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          stall = 1'b0;
   logic          desvio = 1'b0;
   logic [AW-1:0] alvo = '0;
   logic [DW-1:0] instr_mem;
   logic [AW-1:0] endereco;
   logic [DW-1:0] instrucao;
   logic [AW-1:0] pc_instr;
   logic          valido;
   logic          fim;
   logic [15:0]   contador;

   logic [DW-1:0] mem [0:1023];

   int total = 0;
   int bad   = 0;

   unidade_busca #(.LARGURA_END(AW), .LARGURA_DADO(DW), .PALAVRA_FIM('0)) dut (
      .Clk(clk), .Reset(rst), .stall(stall), .desvio(desvio),
      .alvo_desvio(alvo), .instr_mem(instr_mem), .endereco(endereco),
      .instrucao(instrucao), .pc_instr(pc_instr), .valido(valido),
      .fim(fim), .contador(contador)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory: data for the address seen at an edge appears after it.
   always @(posedge clk) instr_mem <= mem[endereco];

   // Reference model: tracks which address is delivered next, not RTL registers.
   bit          m_primed;
   int          m_next;
   logic        m_valid;
   logic        m_fim;
   logic [31:0] m_instr;
   int          m_pc;
   int          m_cnt;

   task automatic m_reset();
      m_primed = 0; m_next = 0; m_valid = 0; m_fim = 0;
      m_instr = '0; m_pc = 0; m_cnt = 0;
   endtask

   task automatic m_step(input logic s, input logic d, input int tgt);
      if (d) begin
         m_valid = 0; m_fim = 0; m_next = tgt; m_primed = 1;
      end else if (!m_primed) begin
         m_primed = 1; m_valid = 0;
      end else if (m_fim || s) begin
         if (m_fim) m_valid = 0;
      end else if (mem[m_next] == 32'd0) begin
         m_valid = 0; m_fim = 1;
      end else begin
         m_instr = mem[m_next];
         m_pc    = m_next;
         m_valid = 1;
         m_next  = (m_next + 1) % 1024;
         if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
   endtask

   task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
      end
   endtask

   task automatic edge_();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      stall = 0; desvio = 0; alvo = '0;
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      m_reset();
   endtask

   task automatic fill_dir();
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i);
      mem[23] = 32'd0;
   endtask

   typedef struct {
      logic          st;
      logic          ds;
      logic [AW-1:0] tg;
      logic          ev;
      logic [AW-1:0] epc;
      logic [15:0]   ecnt;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic ds, input int tg,
                               input logic ev, input int epc, input int ecnt);
      vec_t v;
      v.st = st; v.ds = ds; v.tg = AW'(tg); v.ev = ev; v.epc = AW'(epc); v.ecnt = 16'(ecnt);
      return v;
   endfunction

   vec_t tab [19];

   initial begin
      tab[0]  = mk(1, 0, 0,  0, 0,  0);   // stall ignored on the first edge
      tab[1]  = mk(0, 0, 0,  1, 0,  1);
      tab[2]  = mk(0, 0, 0,  1, 1,  2);
      tab[3]  = mk(0, 0, 0,  1, 2,  3);
      tab[4]  = mk(0, 0, 0,  1, 3,  4);
      tab[5]  = mk(0, 1, 12, 0, 0,  4);   // branch at pc 3
      tab[6]  = mk(0, 0, 0,  1, 12, 5);
      tab[7]  = mk(0, 0, 0,  1, 13, 6);
      tab[8]  = mk(0, 1, 4,  0, 0,  6);
      tab[9]  = mk(0, 0, 0,  1, 4,  7);
      tab[10] = mk(0, 0, 0,  1, 5,  8);
      tab[11] = mk(1, 0, 0,  1, 5,  8);   // three stall cycles at pc 5
      tab[12] = mk(1, 0, 0,  1, 5,  8);
      tab[13] = mk(1, 0, 0,  1, 5,  8);
      tab[14] = mk(0, 0, 0,  1, 6,  9);
      tab[15] = mk(0, 0, 0,  1, 7,  10);
      tab[16] = mk(1, 1, 8,  0, 0,  10);  // redirect beats stall
      tab[17] = mk(0, 0, 0,  1, 8,  11);
      tab[18] = mk(0, 0, 0,  1, 9,  12);

      // Reset state and plain stream up to the terminator at word 23.
      fill_dir();
      do_reset();
      chk("rst_valido", valido, 0);
      chk("rst_fim", fim, 0);
      chk("rst_contador", contador, 0);
      chk("rst_instrucao", instrucao, 0);
      chk("rst_pc_instr", pc_instr, 0);
      chk("rst_endereco", endereco, 0);
      for (int e = 1; e <= 25; e++) begin
         edge_();
         if (e == 1) begin
            chk("strm_bubble", valido, 0);
         end else if (e <= 24) begin
            chk("strm_valido", valido, 1);
            chk("strm_pc", pc_instr, e - 2);
            chk("strm_instr", instrucao, mem[e - 2]);
         end else begin
            chk("strm_fim", fim, 1);
            chk("strm_fim_valido", valido, 0);
            chk("strm_contador", contador, 23);
         end
      end
      stall = 1;
      for (int e = 0; e < 2; e++) begin
         edge_();
         chk("fim_hold", fim, 1);
         chk("fim_hold_valido", valido, 0);
         chk("fim_hold_cnt", contador, 23);
      end
      stall = 0;
      chk("fim_endereco", endereco, 23);
      // Redirect out of FIM to address 0.
      desvio = 1; alvo = 10'd0;
      #1;
      chk("fim_desvio_endereco", endereco, 0);
      edge_();
      desvio = 0;
      chk("fim_desvio_fim", fim, 0);
      chk("fim_desvio_valido", valido, 0);
      edge_();
      chk("fim_desvio_v1", valido, 1);
      chk("fim_desvio_pc", pc_instr, 0);
      chk("fim_desvio_instr", instrucao, mem[0]);

      // Table of stall/branch vectors from a fresh reset.
      do_reset();
      for (int i = 0; i < 19; i++) begin
         stall = tab[i].st; desvio = tab[i].ds; alvo = tab[i].tg;
         #1;
         if (tab[i].ds) chk("tab_endereco", endereco, tab[i].tg);
         edge_();
         chk("tab_valido", valido, tab[i].ev);
         chk("tab_contador", contador, tab[i].ecnt);
         if (tab[i].ev) begin
            chk("tab_pc", pc_instr, tab[i].epc);
            chk("tab_instr", instrucao, mem[tab[i].epc]);
         end
      end
      stall = 0; desvio = 0;

      // Redirect in the same cycle the terminator is on instr_mem.
      do_reset();
      for (int e = 1; e <= 24; e++) edge_();
      chk("term_pre_pc", pc_instr, 22);
      desvio = 1; alvo = 10'd5;
      edge_();
      desvio = 0;
      chk("term_fim", fim, 0);
      chk("term_valido", valido, 0);
      edge_();
      chk("term_pc", pc_instr, 5);
      chk("term_v", valido, 1);

      // Address wrap at 1023.
      mem[23] = 32'hA500_0017;
      do_reset();
      for (int e = 0; e < 3; e++) edge_();
      desvio = 1; alvo = 10'd1022;
      edge_();
      desvio = 0;
      chk("wrap_bubble", valido, 0);
      for (int k = 0; k < 4; k++) begin
         edge_();
         chk("wrap_pc", pc_instr, (1022 + k) % 1024);
         chk("wrap_instr", instrucao, mem[(1022 + k) % 1024]);
      end

      // Asynchronous reset between edges, then restart from 0.
      @(posedge clk);
      #3 rst = 1;
      #1;
      chk("arst_valido", valido, 0);
      chk("arst_fim", fim, 0);
      chk("arst_cnt", contador, 0);
      chk("arst_instr", instrucao, 0);
      chk("arst_pc", pc_instr, 0);
      chk("arst_endereco", endereco, 0);
      @(negedge clk);
      rst = 0;
      edge_();
      chk("arst_e1_valido", valido, 0);
      edge_();
      chk("arst_e2_pc", pc_instr, 0);
      chk("arst_e2_instr", instrucao, mem[0]);
      chk("arst_e2_valido", valido, 1);

      // Random stimulus against the reference model.
      for (int i = 0; i < 1024; i++)
         mem[i] = ($urandom_range(0, 19) == 0) ? 32'd0 : ($urandom | 32'd1);
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         stall  = ($urandom_range(0, 3) == 0);
         desvio = ($urandom_range(0, 11) == 0);
         alvo   = AW'($urandom_range(0, 1023));
         #1;
         if (desvio) chk("rnd_endereco", endereco, alvo);
         edge_();
         m_step(stall, desvio, int'(alvo));
         chk("rnd_valido", valido, m_valid);
         chk("rnd_fim", fim, m_fim);
         chk("rnd_contador", contador, m_cnt);
         chk("rnd_pc", pc_instr, m_pc);
         chk("rnd_instr", instrucao, m_instr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
